axis_fir_tf: RTL and testbench



---
 rtl/fir_pkg.sv | 34 +++
 rtl/fir_tap_tf.sv | 29 ++
 rtl/axis_fir_tf.sv | 128 ++++++++++++
 tb/tb_axis_fir_tf.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and arithmetic helpers for the transposed-form AXI-Stream FIR.
package fir_pkg;

    // Coefficient loader states: fill the shadow bank, then swap it in for one cycle.
    typedef enum logic {
        ST_LOAD   = 1'b0,
        ST_COMMIT = 1'b1
    } ld_state_e;

    // Accumulator width that cannot wrap for any sum of TAPS full-scale products.
    function automatic int acc_width(input int dw, input int cw, input int taps);
        return dw + cw + $clog2(taps);
    endfunction

    // Round half up, then drop SH LSBs (arithmetic shift keeps the sign).
    function automatic logic signed [63:0] round_shift(input logic signed [63:0] v, input int sh);
        logic signed [63:0] r;
        r = v;
        if (sh > 0) r = (v + (64'sd1 <<< (sh - 1))) >>> sh;
        return r;
    endfunction

    // Clip to the signed range of an OW-bit output.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int ow);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/fir_tap_tf.sv
// One transposed-form FIR tap: z_out <= z_in + x*h on every accepted sample.
module fir_tap_tf #(
    parameter int DATA_WIDTH = 16,
    parameter int COE_WIDTH  = 16,
    parameter int ACC_WIDTH  = 35
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic                  en_i,
    input  logic [DATA_WIDTH-1:0] x_i,
    input  logic [COE_WIDTH-1:0]  h_i,
    input  logic [ACC_WIDTH-1:0]  z_i,
    output logic [ACC_WIDTH-1:0]  z_o
);

    logic signed [ACC_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0] z_q;

    // Both operands sign-extended to the accumulator width before multiplying.
    assign prod = ACC_WIDTH'(signed'(x_i)) * ACC_WIDTH'(signed'(h_i));
    assign z_o  = z_q;

    // Partial sum advances only when the stream moves; otherwise it holds.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i)    z_q <= '0;
        else if (en_i) z_q <= prod + signed'(z_i);
    end

endmodule

// File: rtl/axis_fir_tf.sv
// Transposed-form FIR with AXI-Stream ports, round/saturate output stage and
// double-buffered coefficient reload that never stalls the sample stream.
module axis_fir_tf
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int COE_WIDTH  = 16,
    parameter int TAPS       = 8,
    parameter int OUT_WIDTH  = 16,
    parameter int SHIFT      = 15
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_i,
    input  logic                  s_axis_tvalid_i,
    input  logic                  s_axis_tlast_i,
    output logic                  s_axis_tready_o,
    output logic [OUT_WIDTH-1:0]  m_axis_tdata_o,
    output logic                  m_axis_tvalid_o,
    output logic                  m_axis_tlast_o,
    input  logic                  m_axis_tready_i,
    input  logic [COE_WIDTH-1:0]  coe_data_i,
    input  logic                  coe_valid_i,
    output logic                  coe_ready_o,
    output logic                  ovf_o
);

    localparam int ACC_WIDTH = acc_width(DATA_WIDTH, COE_WIDTH, TAPS);
    localparam int IDX_W     = $clog2(TAPS);

    logic                            accept;
    ld_state_e                       state_q;
    logic [IDX_W-1:0]                idx_q;
    logic [TAPS-1:0][COE_WIDTH-1:0]  shadow_q;
    logic [TAPS-1:0][COE_WIDTH-1:0]  active_q;
    logic                            coe_ready_q;
    logic [TAPS:1][ACC_WIDTH-1:0]    z;
    logic signed [ACC_WIDTH-1:0]     y_acc;
    logic signed [63:0]              y_rnd;
    logic signed [63:0]              y_sat;
    logic [OUT_WIDTH-1:0]            tdata_q;
    logic                            tvalid_q;
    logic                            tlast_q;
    logic                            ovf_q;

    // The output register is the only buffer, so input may move when it is free or draining.
    assign s_axis_tready_o = ~tvalid_q | m_axis_tready_i;
    assign accept          = s_axis_tvalid_i & s_axis_tready_o;
    assign coe_ready_o     = coe_ready_q;
    assign m_axis_tdata_o  = tdata_q;
    assign m_axis_tvalid_o = tvalid_q;
    assign m_axis_tlast_o  = tlast_q;
    assign ovf_o           = ovf_q;

    // Loader: shadow fills h[0] first; the cycle after the last word swaps banks.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q     <= ST_LOAD;
            idx_q       <= '0;
            shadow_q    <= '0;
            active_q    <= '0;
            coe_ready_q <= 1'b1;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (coe_valid_i && coe_ready_q) begin
                        shadow_q[idx_q] <= coe_data_i;
                        if (idx_q == IDX_W'(TAPS - 1)) begin
                            state_q     <= ST_COMMIT;
                            coe_ready_q <= 1'b0;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                ST_COMMIT: begin
                    active_q    <= shadow_q;
                    idx_q       <= '0;
                    state_q     <= ST_LOAD;
                    coe_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Taps 1..TAPS-1 form the delay chain; the last tap sees a zero partial sum.
    assign z[TAPS] = '0;
    for (genvar k = 1; k < TAPS; k++) begin : g_tap
        fir_tap_tf #(
            .DATA_WIDTH(DATA_WIDTH),
            .COE_WIDTH (COE_WIDTH),
            .ACC_WIDTH (ACC_WIDTH)
        ) u_tap (
            .clk_i (clk_i),
            .arst_i(arst_i),
            .en_i  (accept),
            .x_i   (s_axis_tdata_i),
            .h_i   (active_q[k]),
            .z_i   (z[k+1]),
            .z_o   (z[k])
        );
    end

    // Tap 0 feeds the output stage directly, so the result lands one edge after accept.
    assign y_acc = ACC_WIDTH'(signed'(s_axis_tdata_i)) * ACC_WIDTH'(signed'(active_q[0]))
                 + signed'(z[1]);
    assign y_rnd = round_shift(64'(y_acc), SHIFT);
    assign y_sat = saturate(y_rnd, OUT_WIDTH);

    // Output register: load on accept, drop valid once the consumer takes it.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            tdata_q  <= OUT_WIDTH'(y_sat);
            tvalid_q <= 1'b1;
            tlast_q  <= s_axis_tlast_i;
            ovf_q    <= (y_sat != y_rnd);
        end else begin
            ovf_q <= 1'b0;
            if (m_axis_tready_i) tvalid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_fir_tf.sv
// Bench for axis_fir_tf: two instances (SHIFT=0 and SHIFT=15) share stimulus; a
// direct-form reference with per-sample coefficient history feeds a scoreboard.
module tb_axis_fir_tf;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        arst;
    logic [15:0] s_tdata;
    logic        s_tvalid, s_tlast, m_tready;
    logic [15:0] coe_data;
    logic        coe_valid;

    logic        a_sready, a_mvalid, a_mlast, a_cready, a_ovf;
    logic [15:0] a_mdata;
    logic        b_sready, b_mvalid, b_mlast, b_cready, b_ovf;
    logic [15:0] b_mdata;

    always #5 clk = ~clk;

    axis_fir_tf #(.DATA_WIDTH(16), .COE_WIDTH(16), .TAPS(T), .OUT_WIDTH(16), .SHIFT(0)) u_d0 (
        .clk_i(clk), .arst_i(arst),
        .s_axis_tdata_i(s_tdata), .s_axis_tvalid_i(s_tvalid), .s_axis_tlast_i(s_tlast),
        .s_axis_tready_o(a_sready),
        .m_axis_tdata_o(a_mdata), .m_axis_tvalid_o(a_mvalid), .m_axis_tlast_o(a_mlast),
        .m_axis_tready_i(m_tready),
        .coe_data_i(coe_data), .coe_valid_i(coe_valid), .coe_ready_o(a_cready), .ovf_o(a_ovf)
    );

    axis_fir_tf #(.DATA_WIDTH(16), .COE_WIDTH(16), .TAPS(T), .OUT_WIDTH(16), .SHIFT(15)) u_d15 (
        .clk_i(clk), .arst_i(arst),
        .s_axis_tdata_i(s_tdata), .s_axis_tvalid_i(s_tvalid), .s_axis_tlast_i(s_tlast),
        .s_axis_tready_o(b_sready),
        .m_axis_tdata_o(b_mdata), .m_axis_tvalid_o(b_mvalid), .m_axis_tlast_o(b_mlast),
        .m_axis_tready_i(m_tready),
        .coe_data_i(coe_data), .coe_valid_i(coe_valid), .coe_ready_o(b_cready), .ovf_o(b_ovf)
    );

    typedef struct {
        longint y0;
        bit     o0;
        longint y15;
        bit     o15;
        bit     last;
    } exp_t;

    // Reference state: loader, banks, and each accepted sample with the bank it saw.
    int   shadow[T], active[T], hx[T];
    int   hh[T][T];
    int   idx;
    bit   commit_st, mvalid, last_acc;
    int   lowcnt;
    exp_t sb[$];
    exp_t cur;
    int   nchk = 0, nerr = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint rnd_sat(input longint acc, input int sh, output bit ovf);
        longint r;
        r = acc;
        if (sh > 0) r = (acc + (longint'(1) << (sh - 1))) >>> sh;
        ovf = (r > 32767) || (r < -32768);
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < T; k++) begin
            shadow[k] = 0; active[k] = 0; hx[k] = 0;
            for (int j = 0; j < T; j++) hh[k][j] = 0;
        end
        idx = 0; commit_st = 0; mvalid = 0;
        sb.delete();
    endtask

    // One clock: check pre-edge handshake outputs, advance the model, check post-edge outputs.
    task automatic tick();
        bit     acc;
        longint s;
        exp_t   e;
        @(negedge clk);
        chk("s_tready_d0", a_sready, (!mvalid || m_tready));
        chk("s_tready_d15", b_sready, (!mvalid || m_tready));
        chk("coe_ready", a_cready, !commit_st);
        if (!a_cready) lowcnt++;
        acc = s_tvalid && (!mvalid || m_tready);
        if (acc) begin
            for (int k = T - 1; k > 0; k--) begin
                hx[k] = hx[k-1];
                hh[k] = hh[k-1];
            end
            hx[0] = $signed(s_tdata);
            hh[0] = active;
            s = 0;
            for (int k = 0; k < T; k++) s += longint'(hx[k]) * longint'(hh[k][k]);
            e.y0   = rnd_sat(s, 0, e.o0);
            e.y15  = rnd_sat(s, 15, e.o15);
            e.last = s_tlast;
            sb.push_back(e);
        end
        if (commit_st) begin
            active = shadow; idx = 0; commit_st = 0;
        end else if (coe_valid) begin
            shadow[idx] = $signed(coe_data);
            if (idx == T - 1) commit_st = 1;
            else idx++;
        end
        if (acc) mvalid = 1;
        else if (m_tready) mvalid = 0;
        last_acc = acc;
        @(posedge clk); #1;
        chk("m_tvalid_d0", a_mvalid, mvalid);
        chk("m_tvalid_d15", b_mvalid, mvalid);
        if (acc) begin
            cur = sb.pop_front();
            chk("tdata_d0", $signed(a_mdata), cur.y0);
            chk("tdata_d15", $signed(b_mdata), cur.y15);
            chk("tlast", a_mlast, cur.last);
            chk("ovf_d0", a_ovf, cur.o0);
            chk("ovf_d15", b_ovf, cur.o15);
        end else begin
            chk("ovf_idle_d0", a_ovf, 0);
            chk("ovf_idle_d15", b_ovf, 0);
            if (mvalid) chk("hold_d0", $signed(a_mdata), cur.y0);
        end
    endtask

    task automatic send(input int x, input bit last);
        int n;
        s_tvalid = 1'b1; s_tdata = 16'(x); s_tlast = last;
        n = 0;
        do begin tick(); n++; end while (!last_acc && n < 50);
        chk("send_timeout", last_acc, 1);
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    // Eight coefficient words, then one more cycle for the bank swap.
    task automatic load(input int c0, input int step, input bit only0);
        coe_valid = 1'b1;
        for (int k = 0; k < T; k++) begin
            coe_data = only0 ? ((k == 0) ? 16'(c0) : 16'd0) : 16'(c0 + step * k);
            tick();
        end
        coe_valid = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        arst = 1'b1; s_tvalid = 1'b0; coe_valid = 1'b0;
        #2;
        chk("rst_tvalid", a_mvalid, 0);
        chk("rst_tdata", a_mdata, 0);
        chk("rst_tlast", a_mlast, 0);
        chk("rst_ovf", a_ovf, 0);
        chk("rst_coe_ready", a_cready, 1);
        chk("rst_tdata_d15", b_mdata, 0);
        model_clear();
        @(posedge clk); #1;
        arst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        arst = 1'b1; s_tdata = '0; s_tvalid = 0; s_tlast = 0; m_tready = 1;
        coe_data = '0; coe_valid = 0; lowcnt = 0;
        model_clear();
        cur = '{0, 0, 0, 0, 0};
        #1;
        do_reset();

        // Before any load the banks are zero, so every output is zero.
        send(100, 0);
        chk("preload_zero", $signed(a_mdata), 0);
        send(-7, 1);

        // Impulse response through h = 1..8.
        load(1, 1, 0);
        for (int i = 0; i < 10; i++) begin
            send((i == 0) ? 1 : 0, (i == 9));
            chk("impulse", $signed(a_mdata), (i < 8) ? i + 1 : 0);
        end

        // Backpressure: sample 11 waits five cycles, output 10 stays put.
        tick();
        m_tready = 1'b0; s_tvalid = 1'b1; s_tdata = 16'd10; s_tlast = 1'b1;
        tick();
        chk("bp_first_accept", last_acc, 1);
        s_tdata = 16'd11; s_tlast = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_stall", last_acc, 0);
        end
        m_tready = 1'b1;
        tick();
        chk("bp_release", last_acc, 1);
        s_tvalid = 1'b0;
        send(12, 0);
        send(-13, 1);

        // Saturation with h[0] = 32767 only; zeros flush the old partial sums first.
        load(32767, 0, 1);
        for (int i = 0; i < T; i++) send(0, 0);
        send(32767, 0);
        chk("sat_pos", $signed(a_mdata), 32767);
        chk("sat_pos_ovf", a_ovf, 1);
        send(-32768, 0);
        chk("sat_neg", $signed(a_mdata), -32768);
        chk("sat_neg_ovf", a_ovf, 1);

        // Rounding on the SHIFT=15 instance with h[0] = 0.5.
        load(16384, 0, 1);
        for (int i = 0; i < T; i++) send(0, 0);
        send(3, 0);
        chk("round_pos", $signed(b_mdata), 2);
        send(-3, 0);
        chk("round_neg", $signed(b_mdata), -1);

        // Mid-stream reload: constant x=1, h all 1 -> all 2 while streaming.
        load(1, 0, 0);
        s_tvalid = 1'b1; s_tdata = 16'd1;
        for (int i = 0; i < 10; i++) tick();
        chk("reload_before", $signed(a_mdata), 8);
        lowcnt = 0;
        load(2, 0, 0);
        for (int i = 0; i < 10; i++) tick();
        chk("reload_after", $signed(a_mdata), 16);
        chk("coe_ready_low_cycles", lowcnt, 1);

        // Reset after 3 of 8 words while streaming; next load must start at h[0].
        coe_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            coe_data = 16'(50 + k);
            tick();
        end
        do_reset();
        load(1, 1, 0);
        send(1, 0);
        chk("post_rst_h0", $signed(a_mdata), 1);
        send(0, 0);
        chk("post_rst_h1", $signed(a_mdata), 2);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
